// File: rtl/vga_controller_if.sv
// rtl/vga_controller_if.sv - display timing bundle from the VGA timing master to the pixel pipeline
interface vga_controller_if #(
    parameter int CNT_W = 10
);
    logic             h_sync_o;
    logic             v_sync_o;
    logic             disp_en_o;
    logic [CNT_W-1:0] x_o;
    logic [CNT_W-1:0] y_o;
    logic             frame_start_o;

    modport master (
        output h_sync_o,
        output v_sync_o,
        output disp_en_o,
        output x_o,
        output y_o,
        output frame_start_o
    );

    modport slave (
        input h_sync_o,
        input v_sync_o,
        input disp_en_o,
        input x_o,
        input y_o,
        input frame_start_o
    );
endinterface

// File: rtl/vga_controller.sv
// rtl/vga_controller.sv - free-running 640x480@60 VGA timing generator (syncs, display enable, coordinates)
module vga_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10
) (
    input  logic               block_clk_i,
    input  logic               rst_high_i,
    vga_controller_if.master   vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;

    // Outputs decode the position held before the edge, so they trail the counters by one clock.
    always_ff @(posedge block_clk_i or posedge rst_high_i) begin
        if (rst_high_i) begin
            h                 <= '0;
            v                 <= '0;
            vga.h_sync_o      <= 1'b1;
            vga.v_sync_o      <= 1'b1;
            vga.disp_en_o     <= 1'b0;
            vga.x_o           <= '0;
            vga.y_o           <= '0;
            vga.frame_start_o <= 1'b0;
        end else begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end

            vga.h_sync_o      <= !((h >= HS_START) && (h < HS_END));
            vga.v_sync_o      <= !((v >= VS_START) && (v < VS_END));
            vga.disp_en_o     <= (h < H_VIS) && (v < V_VIS);
            vga.x_o           <= h;
            vga.y_o           <= v;
            vga.frame_start_o <= (h == '0) && (v == '0);
        end
    end
endmodule

// File: tb/tb_vga_controller.sv
// tb/tb_vga_controller.sv - scoreboard bench for vga_controller, default mode plus a shrunken-timing instance
module tb_vga_controller;
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   pos      = 0;

    exp_t q_d[$];
    exp_t q_s[$];

    int de_cnt_d = 0, hs_low_d = 0, fall0_d = -1, fall1_d = -1, rise0_d = -1;
    int de_cnt_s = 0, vs_low_s = 0, fs_cnt_s = 0;
    logic prev_hs_d = 1'b1;

    always #20 clk = ~clk;

    vga_controller_if #(.CNT_W(10)) vif_d ();
    vga_controller_if #(.CNT_W(10)) vif_s ();

    vga_controller dut_d (
        .block_clk_i (clk),
        .rst_high_i  (rst),
        .vga         (vif_d)
    );

    // 15 x 11 frame so several complete frames fit in a short run.
    vga_controller #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
        .CNT_W(10)
    ) dut_s (
        .block_clk_i (clk),
        .rst_high_i  (rst),
        .vga         (vif_s)
    );

    function automatic exp_t model(int p, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb);
        exp_t m;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int x  = p % ht;
        int y  = (p / ht) % vt;
        m.hs = !((x >= ha + hf) && (x < ha + hf + hsw));
        m.vs = !((y >= va + vf) && (y < va + vf + vsw));
        m.de = (x < ha) && (y < va);
        m.fs = (x == 0) && (y == 0);
        m.x  = 10'(x);
        m.y  = 10'(y);
        return m;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d pos=%0d", tag, obs, expv, pos);
        end
    endtask

    task automatic chk_reset(string pfx);
        chk({pfx, "_d_hs"}, 32'(vif_d.h_sync_o), 1);
        chk({pfx, "_d_vs"}, 32'(vif_d.v_sync_o), 1);
        chk({pfx, "_d_de"}, 32'(vif_d.disp_en_o), 0);
        chk({pfx, "_d_x"},  32'(vif_d.x_o), 0);
        chk({pfx, "_d_y"},  32'(vif_d.y_o), 0);
        chk({pfx, "_d_fs"}, 32'(vif_d.frame_start_o), 0);
        chk({pfx, "_s_hs"}, 32'(vif_s.h_sync_o), 1);
        chk({pfx, "_s_vs"}, 32'(vif_s.v_sync_o), 1);
        chk({pfx, "_s_de"}, 32'(vif_s.disp_en_o), 0);
        chk({pfx, "_s_x"},  32'(vif_s.x_o), 0);
        chk({pfx, "_s_y"},  32'(vif_s.y_o), 0);
        chk({pfx, "_s_fs"}, 32'(vif_s.frame_start_o), 0);
    endtask

    // One clock: push the expected output for the next linear position, then compare after the edge.
    task automatic step();
        exp_t e;
        int   p = pos;
        q_d.push_back(model(p, 640, 16, 96, 48, 480, 10, 2, 33));
        q_s.push_back(model(p, 8, 2, 3, 2, 6, 2, 2, 1));
        @(posedge clk);
        @(negedge clk);
        e = q_d.pop_front();
        chk("d_hs", 32'(vif_d.h_sync_o), 32'(e.hs));
        chk("d_vs", 32'(vif_d.v_sync_o), 32'(e.vs));
        chk("d_de", 32'(vif_d.disp_en_o), 32'(e.de));
        chk("d_fs", 32'(vif_d.frame_start_o), 32'(e.fs));
        chk("d_x",  32'(vif_d.x_o), 32'(e.x));
        chk("d_y",  32'(vif_d.y_o), 32'(e.y));
        e = q_s.pop_front();
        chk("s_hs", 32'(vif_s.h_sync_o), 32'(e.hs));
        chk("s_vs", 32'(vif_s.v_sync_o), 32'(e.vs));
        chk("s_de", 32'(vif_s.disp_en_o), 32'(e.de));
        chk("s_fs", 32'(vif_s.frame_start_o), 32'(e.fs));
        chk("s_x",  32'(vif_s.x_o), 32'(e.x));
        chk("s_y",  32'(vif_s.y_o), 32'(e.y));
        if (p < 1600) begin
            if (vif_d.disp_en_o) de_cnt_d++;
            if (!vif_d.h_sync_o) hs_low_d++;
            if (prev_hs_d && !vif_d.h_sync_o) begin
                if (fall0_d < 0) fall0_d = p;
                else if (fall1_d < 0) fall1_d = p;
            end
            if (!prev_hs_d && vif_d.h_sync_o && rise0_d < 0) rise0_d = p;
        end
        prev_hs_d = vif_d.h_sync_o;
        if (p < 495) begin
            if (vif_s.disp_en_o) de_cnt_s++;
            if (!vif_s.v_sync_o) vs_low_s++;
            if (vif_s.frame_start_o) fs_cnt_s++;
        end
        pos++;
    endtask

    initial begin
        #90;
        chk_reset("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        pos = 0;

        step();
        chk("first_fs", 32'(vif_d.frame_start_o), 1);
        chk("first_de", 32'(vif_d.disp_en_o), 1);
        repeat (1899) step();

        chk("d_hs_fall_x", 32'(fall0_d % 800), 656);
        chk("d_hs_rise_x", 32'(rise0_d % 800), 752);
        chk("d_hs_period", 32'(fall1_d - fall0_d), 800);
        chk("d_hs_low_2lines", 32'(hs_low_d), 192);
        chk("d_de_2lines", 32'(de_cnt_d), 1280);
        chk("s_de_3frames", 32'(de_cnt_s), 144);
        chk("s_vs_low_3frames", 32'(vs_low_s), 90);
        chk("s_fs_3frames", 32'(fs_cnt_s), 3);
        chk("d_x_before_rst", 32'(vif_d.x_o), 299);

        // Mid-line reset between edges: outputs must clear before the next rising edge.
        #5;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        repeat (3) @(negedge clk);
        chk_reset("rst_held");
        rst = 1'b0;
        pos = 0;

        step();
        chk("rerun_fs", 32'(vif_s.frame_start_o), 1);
        repeat (399) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
